// File: rtl/store_buffer_if.sv
// Store-buffer bus: pipeline store/load requests, fence, memory port and status.
// The pipeline side uses the master modport, the store buffer uses the slave modport.
interface store_buffer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  st_valid;
  logic [ADDR_WIDTH-1:0] st_addr;
  logic [DATA_WIDTH-1:0] st_data;
  logic                  st_byte;
  logic                  st_ready;
  logic                  ld_en;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic                  ld_byte;
  logic                  ld_stall;
  logic                  fwd_valid;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic                  flush;
  logic [ADDR_WIDTH-1:0] mem_A;
  logic [DATA_WIDTH-1:0] mem_WD;
  logic                  mem_WE;
  logic                  mem_addr_mode;
  logic                  empty;
  logic [CNT_W-1:0]      count;

  modport master (
    output st_valid, st_addr, st_data, st_byte, ld_en, ld_addr, ld_byte, flush,
    input  st_ready, ld_stall, fwd_valid, fwd_data, mem_A, mem_WD, mem_WE,
           mem_addr_mode, empty, count
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_byte, ld_en, ld_addr, ld_byte, flush,
    output st_ready, ld_stall, fwd_valid, fwd_data, mem_A, mem_WD, mem_WE,
           mem_addr_mode, empty, count
  );
endinterface

// File: rtl/store_buffer.sv
// Posted-write store buffer draining in order to a single-port data memory.
// Define STORE_BUF_FWD_EN to forward data to loads that exactly match pending stores.
module store_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic           clk,
  input  logic           rst,
  store_buffer_if.slave  io_sb
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int RNG_W = ADDR_WIDTH + 2;

  logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]      r_byte;
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;

  logic                  w_st_ready;
  logic                  w_push;
  logic                  w_drain;
  logic                  w_load_owns;
  logic                  w_stall;
  logic                  w_fwd;
  logic [DATA_WIDTH-1:0] w_fwd_data;
  logic [DEPTH-1:0]      w_ov;
  logic [PTR_W-1:0]      w_slot [DEPTH];
  logic [RNG_W-1:0]      w_ld_lo;
  logic [RNG_W-1:0]      w_ld_hi;

  // Ranges are widened by two bits so a word at the top of memory never wraps to 0.
  assign w_ld_lo = {2'b00, io_sb.ld_addr};
  assign w_ld_hi = w_ld_lo + RNG_W'({~io_sb.ld_byte, ~io_sb.ld_byte});

  // Index g is entry age: 0 is the head (oldest), count-1 the youngest.
  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_ov
      logic [RNG_W-1:0] w_lo;
      logic [RNG_W-1:0] w_hi;
      assign w_slot[g] = r_head + PTR_W'(g);
      assign w_lo      = {2'b00, r_addr[w_slot[g]]};
      assign w_hi      = w_lo + RNG_W'({~r_byte[w_slot[g]], ~r_byte[w_slot[g]]});
      assign w_ov[g]   = (CNT_W'(g) < r_count) && (w_ld_lo <= w_hi) && (w_lo <= w_ld_hi);
    end
  endgenerate

`ifdef STORE_BUF_FWD_EN
  logic [DEPTH-1:0]      w_match;
  logic [DATA_WIDTH-1:0] w_sel;

  generate
    for (g = 0; g < DEPTH; g++) begin : g_match
      assign w_match[g] = (r_addr[w_slot[g]] == io_sb.ld_addr) &&
                          (r_byte[w_slot[g]] == io_sb.ld_byte);
    end
  endgenerate

  // Forward only when every overlapping entry has the load's exact range; youngest data wins.
  always_comb begin
    w_sel      = '0;
    w_fwd      = io_sb.ld_en & (|w_ov) & (&(~w_ov | w_match));
    w_fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_ov[i]) w_sel = r_data[w_slot[i]];
    end
    if (w_fwd) begin
      w_fwd_data = io_sb.ld_byte ? {{(DATA_WIDTH-8){1'b0}}, w_sel[7:0]} : w_sel;
    end
  end
`else
  assign w_fwd      = 1'b0;
  assign w_fwd_data = '0;
`endif

  assign w_stall     = io_sb.ld_en & (|w_ov) & ~w_fwd;
  assign w_load_owns = io_sb.ld_en & ~w_stall & ~w_fwd;
  assign w_drain     = ~w_load_owns & (r_count != '0);
  assign w_st_ready  = (r_count != CNT_W'(DEPTH)) & ~io_sb.flush;
  assign w_push      = io_sb.st_valid & w_st_ready;

  assign io_sb.st_ready  = w_st_ready;
  assign io_sb.ld_stall  = w_stall;
  assign io_sb.fwd_valid = w_fwd;
  assign io_sb.fwd_data  = w_fwd_data;
  assign io_sb.empty     = (r_count == '0);
  assign io_sb.count     = r_count;

  always_comb begin
    io_sb.mem_A         = io_sb.ld_addr;
    io_sb.mem_WD        = '0;
    io_sb.mem_WE        = 1'b0;
    io_sb.mem_addr_mode = io_sb.ld_byte;
    if (w_drain) begin
      io_sb.mem_A         = r_addr[r_head];
      io_sb.mem_WD        = r_data[r_head];
      io_sb.mem_WE        = 1'b1;
      io_sb.mem_addr_mode = r_byte[r_head];
    end
  end

  // Entry payload needs no reset: only slots below count are ever looked at.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= io_sb.st_addr;
      r_data[r_tail] <= io_sb.st_data;
      r_byte[r_tail] <= io_sb.st_byte;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)  r_tail <= r_tail + 1'b1;
      if (w_drain) r_head <= r_head + 1'b1;
      case ({w_push, w_drain})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write FIFO placed between the memory-stage store path and the data memory port; the data memory has a combinational read and a write on the clock edge.
- Stores are accepted without stalling the pipeline and drain to memory in order during cycles when no load is using the single memory port.
- Loads that overlap any pending store are stalled until the conflicting entries have drained, so a load never returns stale data.

Parameters:
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 32, byte address width.
- DEPTH, 4, number of buffered stores; must be a power of 2 and at least 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-high reset.
- st_valid  input  1  store request from the memory stage.
- st_addr  input  ADDR_WIDTH  store byte address.
- st_data  input  DATA_WIDTH  store data; only [7:0] is significant for a byte store.
- st_byte  input  1  1 = byte store, 0 = word store.
- st_ready  output  1  buffer can accept a store this cycle.
- ld_en  input  1  load request this cycle.
- ld_addr  input  ADDR_WIDTH  load byte address.
- ld_byte  input  1  1 = byte load, 0 = word load.
- ld_stall  output  1  load conflicts with a pending store; the pipeline holds the load.
- fwd_valid  output  1  load data is supplied from the buffer (optional feature).
- fwd_data  output  DATA_WIDTH  forwarded load data.
- flush  input  1  fence: block new stores until the buffer is empty.
- mem_A  output  ADDR_WIDTH  memory port address.
- mem_WD  output  DATA_WIDTH  memory port write data.
- mem_WE  output  1  memory port write enable.
- mem_addr_mode  output  1  memory port byte mode.
- empty  output  1  no pending stores.
- count  output  $clog2(DEPTH)+1  number of pending stores.

Behaviour:
- Storage: circular FIFO. Each entry holds {addr, data, byte}. Head pointer, tail pointer and count are registers.
- Reset (async, rst=1):
  - pointers=0, count=0, empty=1, st_ready=1.
  - mem_WE=0, ld_stall=0, fwd_valid=0, fwd_data=0.
  - Entry contents are don't-care.
  - A reset asserted mid-drain discards all pending stores.
- Push condition: st_valid & st_ready. The entry is written at the tail on the edge; tail and count increment.
- st_ready = (count != DEPTH) & ~flush.
  - It does not depend on a same-cycle drain: no push when full, even while draining.
  - A push with st_ready=0 is ignored.
- Overlap rule:
  - Byte access covers [a,a]; word access covers [a,a+3].
  - Bounds are computed in ADDR_WIDTH+2 bits so there is no wrap at the top of the address space.
  - A load overlaps an entry when the two ranges intersect.
- ld_stall = ld_en & (load overlaps any valid entry) & ~fwd_valid. Combinational.
- Port arbitration, combinational, evaluated each cycle:
  - Load owns the port (ld_en=1 and ld_stall=0): mem_A=ld_addr, mem_addr_mode=ld_byte, mem_WE=0.
  - Otherwise, if count>0: drain the head. mem_A=head.addr, mem_WD=head.data, mem_addr_mode=head.byte, mem_WE=1. Head increments and count decrements on the edge.
  - Otherwise: mem_WE=0, mem_A=ld_addr, mem_addr_mode=ld_byte.
- A stalled load therefore forces the drain; it is released once the conflicting entries have retired, with one entry retiring per cycle.
- Simultaneous push and drain: count is unchanged. This is legal when count<DEPTH.
- Push-then-load: a store pushed in cycle N is visible to the overlap check for a load in cycle N+1. The memory stage does not issue a load and a store in the same cycle.
- Ordering: memory writes occur in push order. Byte-store semantics are those of the memory's own byte mode.
- flush: st_ready is forced to 0. Draining continues. Software waits for empty=1.
- Wrap-around: pointers wrap at DEPTH, with no bubble.

Optional Feature:
- Macro: STORE_BUF_FWD_EN.
- With the macro defined:
  - If ld_en=1 and the youngest overlapping entry has an identical addr and identical size to the load, and no older entry differs in range, then fwd_valid=1 and ld_stall=0.
  - fwd_data = entry data for a word load; {24'b0, data[7:0]} for a byte load.
  - The port may drain in that cycle.
- Without the macro: fwd_valid and fwd_data are tied to 0, and every overlapping load stalls.

Test Plan:
- Reset then idle:
  - Expect empty=1, count=0, st_ready=1, mem_WE=0.
  - Assert rst mid-drain with count=3 → count=0 and mem_WE=0 immediately.
- Fill:
  - Push word stores 0x100..0x10C with data 0xA0..0xA3 and ld_en=0 throughout.
  - One entry drains per cycle, in order: mem_WE=1 with mem_A=0x100,0x104,0x108,0x10C, then empty=1.
- Back-pressure:
  - Hold ld_en=1 at a non-overlapping address 0x200 and push 5 stores.
  - After 4 pushes st_ready=0 and the 5th is ignored; count stays 4 while the load holds the port.
- Conflict:
  - Pending word store 0x20 to 0x40 behind 2 older entries; load word 0x42.
  - ld_stall=1 for 3 cycles (drains to 0x?, 0x?, 0x40), then ld_stall=0 with mem_A=0x42.
- Byte/word overlap edges:
  - Pending byte store at 0x13; a word load at 0x10 stalls.
  - A word load at 0x14 does not stall.
  - Pending word store at 0xFFFFFFFC with a byte load at 0x0 → no stall (no wrap).
- Forwarding (STORE_BUF_FWD_EN):
  - Word store 0xDEADBEEF to 0x80, then word load 0x80 → fwd_valid=1, fwd_data=0xDEADBEEF, ld_stall=0.
  - Byte load 0x80 → stall (size mismatch); without the macro the word load stalls.
